// File: rtl/float_mul_hs.sv
// ============================================================================
//  Module      : float_mul_hs
//  Description : Sequential fp32 multiplier, strobe/ack operand and result ports
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module float_mul_hs (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic [31:0] data_a,
  input  logic        a_stb,
  output logic        a_ack,
  input  logic [31:0] data_b,
  input  logic        b_stb,
  output logic        b_ack,
  output logic [31:0] result,
  output logic        z_stb,
  input  logic        z_ack
);

  typedef enum logic [2:0] {
    S_GET       = 3'd0,
    S_UNPACK    = 3'd1,
    S_SPECIAL   = 3'd2,
    S_MULTIPLY  = 3'd3,
    S_NORMALISE = 3'd4,
    S_ROUND     = 3'd5,
    S_PACK      = 3'd6,
    S_PUT       = 3'd7
  } state_t;

  localparam logic [31:0] C_QNAN = 32'h7FC00000;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic               a_held_q, b_held_q;
  logic               a_ack_q, b_ack_q;
  logic               sa_q, sb_q;
  logic [7:0]         ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        prod_q;
  logic [23:0]        man_q;
  logic               guard_q, sticky_q;
  logic [31:0]        result_q;
  logic               z_stb_q;

  logic               a_nan_d, b_nan_d, a_inf_d, b_inf_d, a_zero_d, b_zero_d;
  logic               round_up_d;
  logic [24:0]        man_rnd_d;

  // Zero/denormal inputs carry ma=0, so only the exponent marks them
  assign a_nan_d    = (ea_q == 8'hFF) && (ma_q[22:0] != 23'd0);
  assign b_nan_d    = (eb_q == 8'hFF) && (mb_q[22:0] != 23'd0);
  assign a_inf_d    = (ea_q == 8'hFF) && (ma_q[22:0] == 23'd0);
  assign b_inf_d    = (eb_q == 8'hFF) && (mb_q[22:0] == 23'd0);
  assign a_zero_d   = (ea_q == 8'h00);
  assign b_zero_d   = (eb_q == 8'h00);
  assign round_up_d = guard_q && (sticky_q || man_q[0]);
  assign man_rnd_d  = {1'b0, man_q} + 25'd1;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q  <= S_GET;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ea_q     <= 8'd0;
      eb_q     <= 8'd0;
      ma_q     <= 24'd0;
      mb_q     <= 24'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      prod_q   <= 48'd0;
      man_q    <= 24'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= 32'd0;
      z_stb_q  <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        S_GET: begin
          if (a_stb && !a_held_q) begin
            a_q      <= data_a;
            a_held_q <= 1'b1;
            a_ack_q  <= 1'b1;
          end
          if (b_stb && !b_held_q) begin
            b_q      <= data_b;
            b_held_q <= 1'b1;
            b_ack_q  <= 1'b1;
          end
          if ((a_held_q || a_stb) && (b_held_q || b_stb)) state_q <= S_UNPACK;
        end
        S_UNPACK: begin
          sa_q    <= a_q[31];
          sb_q    <= b_q[31];
          ea_q    <= a_q[30:23];
          eb_q    <= b_q[30:23];
          ma_q    <= (a_q[30:23] == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
          mb_q    <= (b_q[30:23] == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
          state_q <= S_SPECIAL;
        end
        S_SPECIAL: begin
          if (a_nan_d || b_nan_d || (a_inf_d && b_zero_d) || (b_inf_d && a_zero_d)) begin
            result_q <= C_QNAN;
            state_q  <= S_PUT;
          end else if (a_inf_d || b_inf_d) begin
            result_q <= {sa_q ^ sb_q, 8'hFF, 23'd0};
            state_q  <= S_PUT;
          end else if (a_zero_d || b_zero_d) begin
            result_q <= {sa_q ^ sb_q, 31'd0};
            state_q  <= S_PUT;
          end else begin
            state_q  <= S_MULTIPLY;
          end
        end
        S_MULTIPLY: begin
          sign_q  <= sa_q ^ sb_q;
          exp_q   <= $signed({2'b00, ea_q} + {2'b00, eb_q} - 10'd127);
          prod_q  <= {24'd0, ma_q} * {24'd0, mb_q};
          state_q <= S_NORMALISE;
        end
        S_NORMALISE: begin
          if (prod_q[47]) begin
            man_q    <= prod_q[47:24];
            guard_q  <= prod_q[23];
            sticky_q <= |prod_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            man_q    <= prod_q[46:23];
            guard_q  <= prod_q[22];
            sticky_q <= |prod_q[21:0];
          end
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (round_up_d) begin
            if (man_rnd_d[24]) begin
              man_q <= 24'h800000;
              exp_q <= exp_q + 10'sd1;
            end else begin
              man_q <= man_rnd_d[23:0];
            end
          end
          state_q <= S_PACK;
        end
        S_PACK: begin
          if (exp_q >= 10'sd255)     result_q <= {sign_q, 8'hFF, 23'd0};
          else if (exp_q <= 10'sd0)  result_q <= {sign_q, 31'd0};
          else                       result_q <= {sign_q, exp_q[7:0], man_q[22:0]};
          z_stb_q <= 1'b1;
          state_q <= S_PUT;
        end
        S_PUT: begin
          // Special results arrive without z_stb; it is raised on the first PUT cycle
          if (z_stb_q && z_ack) begin
            z_stb_q  <= 1'b0;
            a_held_q <= 1'b0;
            b_held_q <= 1'b0;
            state_q  <= S_GET;
          end else begin
            z_stb_q  <= 1'b1;
          end
        end
        default: state_q <= S_GET;
      endcase
    end
  end

  assign a_ack  = a_ack_q;
  assign b_ack  = b_ack_q;
  assign result = result_q;
  assign z_stb  = z_stb_q;

endmodule

`default_nettype wire
